// File: rtl/spad_hit_capture.sv
// Hit capture for one TDC window: synchronises the SPAD front-end signals, stamps each hit
// with a coarse cycle count, queues it in a small FIFO and re-arms the front end via rst_auto.
module spad_hit_capture #(
   parameter int unsigned COARSE_W    = 9,
   parameter int unsigned WINDOW      = 512,
   parameter int unsigned MAX_HITS    = 3,
   parameter int unsigned RST_CYCLES  = 4,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic                clk_250M,
   input  logic                rst,
   input  logic                TDC_start,
   input  logic                trig,
   input  logic                time_gate,
   input  logic [15:0]         spad_int,
   output logic                rst_auto,
   output logic                hit_valid,
   input  logic                hit_ready,
   output logic [1:0]          hit_idx,
   output logic [COARSE_W-1:0] hit_coarse,
   output logic [15:0]         hit_int,
   output logic                busy,
   output logic                frame_done,
   output logic                overflow
);

   localparam int unsigned RST_W = $clog2(RST_CYCLES + 1);
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned ENT_W = 2 + COARSE_W + 16;

   localparam logic [COARSE_W-1:0] CoarseLast = COARSE_W'(WINDOW - 1);
   localparam logic [RST_W-1:0]    RstMax     = RST_W'(RST_CYCLES);
   localparam logic [1:0]          HitMax     = 2'(MAX_HITS);
   localparam logic [CNT_W-1:0]    FifoFull   = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {StIdle, StArmed, StReset, StDone} state_e;

   state_e                          state_q, state_d;
   logic [SYNC_STAGES-1:0]          trig_sync_q, trig_sync_d;
   logic [SYNC_STAGES-1:0]          tg_sync_q, tg_sync_d;
   logic [SYNC_STAGES-1:0][15:0]    int_sync_q, int_sync_d;
   logic                            trig_dly_q, trig_dly_d;
   logic                            tdc_dly_q, tdc_dly_d;
   logic [COARSE_W-1:0]             coarse_q, coarse_d, coarse_inc;
   logic [1:0]                      hit_cnt_q, hit_cnt_d;
   logic [RST_W-1:0]                rst_cnt_q, rst_cnt_d;
   logic                            rst_auto_q, rst_auto_d;
   logic                            overflow_q, overflow_d;
   logic [PTR_W-1:0]                rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]                count_q, count_d;
   logic [ENT_W-1:0]                head_q, head_d;
   logic [ENT_W-1:0]                mem_q [FIFO_DEPTH];

   logic trig_s, tg_s, hit_ev, tdc_rise, expiry, push, pop, wr_en;
   logic [15:0]      int_s;
   logic [ENT_W-1:0] push_data;

   assign trig_s    = trig_sync_q[SYNC_STAGES-1];
   assign tg_s      = tg_sync_q[SYNC_STAGES-1];
   assign int_s     = int_sync_q[SYNC_STAGES-1];
   assign hit_ev    = trig_s & ~trig_dly_q;
   assign tdc_rise  = TDC_start & ~tdc_dly_q;
   assign expiry    = (coarse_q == CoarseLast);
   assign push_data = {hit_cnt_q, coarse_q, int_s};
   assign pop       = hit_valid & hit_ready;

   always_comb begin
      trig_sync_d = {trig_sync_q[SYNC_STAGES-2:0], trig};
      tg_sync_d   = {tg_sync_q[SYNC_STAGES-2:0], time_gate};
      int_sync_d  = {int_sync_q[SYNC_STAGES-2:0], spad_int};
      trig_dly_d  = trig_s;
      tdc_dly_d   = TDC_start;
      state_d     = state_q;
      coarse_d    = coarse_q;
      hit_cnt_d   = hit_cnt_q;
      rst_cnt_d   = rst_cnt_q;
      rst_auto_d  = 1'b0;
      overflow_d  = overflow_q;
      push        = 1'b0;
      coarse_inc  = expiry ? coarse_q : coarse_q + 1'b1;

      case (state_q)
         StIdle: begin
            if (tdc_rise) begin
               hit_cnt_d  = '0;
               overflow_d = 1'b0;
               coarse_d   = '0;
               state_d    = StArmed;
            end
         end
         StArmed: begin
            coarse_d = coarse_inc;
            if (hit_ev) begin
               push      = 1'b1;
               hit_cnt_d = hit_cnt_q + 1'b1;
               rst_cnt_d = '0;
               state_d   = StReset;
            end else if (expiry) begin
               state_d = StDone;
            end
         end
         StReset: begin
            coarse_d = coarse_inc;
            if (rst_cnt_q == RstMax && !trig_s) begin
               state_d = (hit_cnt_q == HitMax || expiry) ? StDone : StArmed;
            end else begin
               // rst_cnt tracks how many cycles rst_auto has been driven, so it
               // advances together with the registered pulse.
               rst_auto_d = (rst_cnt_q < RstMax) & ~tg_s;
               rst_cnt_d  = rst_cnt_q + RST_W'(rst_auto_d);
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // A full FIFO still accepts a push when the head leaves in the same cycle.
      wr_en = push & ((count_q != FifoFull) | pop);
      if (push && !wr_en) overflow_d = 1'b1;

      wr_ptr_d = wr_ptr_q + PTR_W'(wr_en);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      count_d  = count_q + CNT_W'(wr_en) - CNT_W'(pop);

      if (count_d == '0) begin
         head_d = '0;
      end else if (wr_en && wr_ptr_q == rd_ptr_d) begin
         head_d = push_data;
      end else begin
         head_d = mem_q[rd_ptr_d];
      end
   end

   always_ff @(posedge clk_250M) begin
      if (rst) begin
         state_q     <= StIdle;
         trig_sync_q <= '0;
         tg_sync_q   <= '0;
         int_sync_q  <= '0;
         trig_dly_q  <= 1'b0;
         tdc_dly_q   <= 1'b0;
         coarse_q    <= '0;
         hit_cnt_q   <= '0;
         rst_cnt_q   <= '0;
         rst_auto_q  <= 1'b0;
         overflow_q  <= 1'b0;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         head_q      <= '0;
      end else begin
         state_q     <= state_d;
         trig_sync_q <= trig_sync_d;
         tg_sync_q   <= tg_sync_d;
         int_sync_q  <= int_sync_d;
         trig_dly_q  <= trig_dly_d;
         tdc_dly_q   <= tdc_dly_d;
         coarse_q    <= coarse_d;
         hit_cnt_q   <= hit_cnt_d;
         rst_cnt_q   <= rst_cnt_d;
         rst_auto_q  <= rst_auto_d;
         overflow_q  <= overflow_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         head_q      <= head_d;
      end
   end

   always_ff @(posedge clk_250M) begin
      if (wr_en) mem_q[wr_ptr_q] <= push_data;
   end

   assign rst_auto                         = rst_auto_q;
   assign hit_valid                        = (count_q != '0);
   assign {hit_idx, hit_coarse, hit_int}   = head_q;
   assign busy                             = (state_q != StIdle);
   assign frame_done                       = (state_q == StDone);
   assign overflow                         = overflow_q;

endmodule
